// File: rtl/usrt_tx.sv
//------------------------------------------------------------------------------
// Module : usrt_tx
// Brief  : USRT transmit stage. Byte FIFO fed by the APB transmit-register
//          strobe, serialised with a generated bit clock. Even parity is
//          compiled in when USRT_TX_PARITY_EN is defined.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module usrt_tx #(
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst,
  input  logic                     i_Tx_En,
  input  logic [31:0]              i_Pwdata,
  input  logic                     i_Ovf_Clr,
  output logic                     o_Tx_Serial,
  output logic                     o_Tx_Clk,
  output logic                     o_Tx_Busy,
  output logic                     o_Fifo_Empty,
  output logic                     o_Fifo_Full,
  output logic [$clog2(DEPTH):0]   o_Fifo_Count,
  output logic                     o_Ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [BW-1:0] LAST_CNT = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_M1  = BW'(CLKS_PER_BIT / 2 - 1);

`ifdef USRT_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop, last, ovf;
  logic [7:0]    head;

  state_t        state;
  logic [BW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tx_serial, tx_clk, tx_busy;
`ifdef USRT_TX_PARITY_EN
  logic          parity;
`endif

  logic unused_pwdata;
  assign unused_pwdata = ^i_Pwdata[31:8];

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = i_Tx_En && !full;
  assign last  = (bit_cnt == LAST_CNT);
  assign head  = mem[rd_ptr];

  // Pop on leaving IDLE or on the final stop-bit cycle (back-to-back frames).
  always_comb begin
    pop = 1'b0;
    if (!empty && ((state == IDLE) || ((state == STOP) && last)))
      pop = 1'b1;
  end

  always_ff @(posedge i_Clk) begin
    if (push)
      mem[wr_ptr] <= i_Pwdata[7:0];
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A dropped write sets the flag even when a clear arrives in the same cycle.
  always_ff @(posedge i_Clk) begin
    if (i_Rst)
      ovf <= 1'b0;
    else if (i_Tx_En && full)
      ovf <= 1'b1;
    else if (i_Ovf_Clr)
      ovf <= 1'b0;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      tx_serial <= 1'b1;
      tx_clk    <= 1'b1;
      tx_busy   <= 1'b0;
`ifdef USRT_TX_PARITY_EN
      parity    <= 1'b0;
`endif
    end else if (state == IDLE) begin
      bit_cnt <= '0;
      if (pop) begin
        shreg     <= head;
`ifdef USRT_TX_PARITY_EN
        parity    <= ^head;
`endif
        state     <= START;
        tx_serial <= 1'b0;
        tx_clk    <= 1'b0;
        tx_busy   <= 1'b1;
      end
    end else if (!last) begin
      bit_cnt <= bit_cnt + BW'(1);
      if (bit_cnt == HALF_M1)
        tx_clk <= 1'b1;
    end else begin
      bit_cnt <= '0;
      tx_clk  <= 1'b0;
      case (state)
        START: begin
          state     <= DATA;
          bit_idx   <= 3'd0;
          tx_serial <= shreg[0];
          shreg     <= {1'b0, shreg[7:1]};
        end
        DATA: begin
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef USRT_TX_PARITY_EN
            state     <= PARITY;
            tx_serial <= parity;
`else
            state     <= STOP;
            tx_serial <= 1'b1;
`endif
          end else begin
            tx_serial <= shreg[0];
            shreg     <= {1'b0, shreg[7:1]};
          end
        end
`ifdef USRT_TX_PARITY_EN
        PARITY: begin
          state     <= STOP;
          tx_serial <= 1'b1;
        end
`endif
        STOP: begin
          if (pop) begin
            shreg     <= head;
`ifdef USRT_TX_PARITY_EN
            parity    <= ^head;
`endif
            state     <= START;
            tx_serial <= 1'b0;
          end else begin
            state     <= IDLE;
            tx_serial <= 1'b1;
            tx_clk    <= 1'b1;
            tx_busy   <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          tx_serial <= 1'b1;
          tx_clk    <= 1'b1;
          tx_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign o_Tx_Serial  = tx_serial;
  assign o_Tx_Clk     = tx_clk;
  assign o_Tx_Busy    = tx_busy;
  assign o_Fifo_Empty = empty;
  assign o_Fifo_Full  = full;
  assign o_Fifo_Count = count;
  assign o_Ovf        = ovf;

endmodule

`default_nettype wire

// File: tb/tb_usrt_tx.sv
//------------------------------------------------------------------------------
// Module : tb_usrt_tx
// Brief  : Self-checking bench for usrt_tx (DEPTH=4, CLKS_PER_BIT=4).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_usrt_tx;

  localparam int DEPTH = 4;
  localparam int CPB   = 4;
`ifdef USRT_TX_PARITY_EN
  localparam int F = 11;
`else
  localparam int F = 10;
`endif
  localparam int FRAME = F * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_en = 1'b0;
  logic        ovf_clr = 1'b0;
  logic [31:0] pwdata = '0;
  logic        o_Tx_Serial, o_Tx_Clk, o_Tx_Busy, o_Fifo_Empty, o_Fifo_Full, o_Ovf;
  logic [2:0]  o_Fifo_Count;

  usrt_tx #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Tx_En(tx_en), .i_Pwdata(pwdata), .i_Ovf_Clr(ovf_clr),
    .o_Tx_Serial(o_Tx_Serial), .o_Tx_Clk(o_Tx_Clk), .o_Tx_Busy(o_Tx_Busy),
    .o_Fifo_Empty(o_Fifo_Empty), .o_Fifo_Full(o_Fifo_Full),
    .o_Fifo_Count(o_Fifo_Count), .o_Ovf(o_Ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: queue of accepted bytes, cycles left in the current frame.
  logic [7:0] m_q[$];
  logic [7:0] exp_tx[$];
  int         m_left = 0;
  bit         m_ovf = 1'b0;

  always @(posedge clk) begin
    int pre;
    pre = m_q.size();
    if (rst) begin
      m_q.delete();
      exp_tx.delete();
      m_left = 0;
      m_ovf  = 1'b0;
    end else begin
      if (m_left <= 1 && pre > 0) begin
        exp_tx.push_back(m_q.pop_front());
        m_left = FRAME;
      end else if (m_left > 0) begin
        m_left--;
      end
      if (tx_en && pre < DEPTH) m_q.push_back(pwdata[7:0]);
      if (tx_en && pre == DEPTH) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
    end
  end

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic p);
`ifdef USRT_TX_PARITY_EN
    return {1'b1, p, d, 1'b0};
`else
    return {1'b0, 1'b1, d, 1'b0};
`endif
  endfunction

  // Status checker and line monitor: bits sampled on rising o_Tx_Clk.
  bit          chk_en = 1'b0;
  logic [10:0] rx_bits = '0;
  int          rx_n = 0;
  logic        prev_clk = 1'b1;

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("count", 32'(o_Fifo_Count), m_q.size());
      check("empty", o_Fifo_Empty, m_q.size() == 0);
      check("full",  o_Fifo_Full,  m_q.size() == DEPTH);
      check("ovf",   o_Ovf, m_ovf);
      check("busy",  o_Tx_Busy, m_left > 0);
      if (m_left == 0) check("idle_line", {o_Tx_Serial, o_Tx_Clk}, 2'b11);
    end
    if (!o_Tx_Busy) begin
      rx_n    = 0;
      rx_bits = '0;
    end else if (!prev_clk && o_Tx_Clk) begin
      rx_bits[rx_n] = o_Tx_Serial;
      rx_n++;
      if (rx_n == F) begin
        check("rx_pending", exp_tx.size() > 0, 1);
        if (exp_tx.size() > 0) begin
          logic [7:0] e;
          e = exp_tx.pop_front();
          check("rx_frame", rx_bits, mk_frame(e, ^e));
        end
        rx_n    = 0;
        rx_bits = '0;
      end
    end
    prev_clk = o_Tx_Clk;
  end

  task automatic drain();
    int i;
    for (i = 0; i < (DEPTH + 2) * FRAME; i++) begin
      if (m_q.size() == 0 && m_left == 0) break;
      tick();
    end
    check("drain_done", (m_q.size() == 0) && (m_left == 0), 1);
  endtask

  // Single byte with exact latency, mid-bit sampled frame and busy duration.
  task automatic single(input logic [7:0] d, input logic p);
    logic [10:0] bits;
    int          nb;
    logic        pc;
    tx_en  = 1'b1;
    pwdata = {$urandom_range(0, 32'hFFFFFF) & 24'hFFFFFF, d};
    tick();
    tx_en = 1'b0;
    check("wr_count", 32'(o_Fifo_Count), 1);
    check("pre_start", o_Tx_Serial, 1);
    tick();
    check("start_bit", o_Tx_Serial, 0);
    check("busy_rise", o_Tx_Busy, 1);
    bits = '0;
    nb   = 0;
    pc   = o_Tx_Clk;
    for (int c = 1; c < FRAME; c++) begin
      tick();
      if (!pc && o_Tx_Clk) begin
        if (nb < 11) bits[nb] = o_Tx_Serial;
        nb++;
      end
      pc = o_Tx_Clk;
    end
    check("busy_last", o_Tx_Busy, 1);
    check("nbits", nb, F);
    check("frame", bits, mk_frame(d, p));
    tick();
    check("busy_fall", o_Tx_Busy, 0);
    check("stop_idle", o_Tx_Serial, 1);
  endtask

  typedef struct packed {
    logic [7:0] d;
    logic       p;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{d: 8'hA5, p: 1'b0};
    tbl[1] = '{d: 8'h01, p: 1'b1};
    tbl[2] = '{d: 8'hFF, p: 1'b0};
    tbl[3] = '{d: 8'h80, p: 1'b1};
    tbl[4] = '{d: 8'h00, p: 1'b0};
    tbl[5] = '{d: 8'h7F, p: 1'b1};

    // Reset
    rst = 1'b1;
    repeat (2) tick();
    check("rst_line", {o_Tx_Serial, o_Tx_Clk, o_Tx_Busy}, 3'b110);
    check("rst_fifo", {o_Fifo_Empty, o_Fifo_Full, o_Fifo_Count, o_Ovf}, 6'b10_000_0);
    rst = 1'b0;
    chk_en = 1'b1;
    tick();

    // Table-driven single frames
    for (int i = 0; i < 6; i++) begin
      single(tbl[i].d, tbl[i].p);
      drain();
    end

    // Back-to-back frames with no idle gap
    begin
      int gaps;
      tx_en = 1'b1; pwdata = 32'h01; tick();
      pwdata = 32'h02; tick();
      pwdata = 32'h03; tick();
      tx_en = 1'b0;
      check("b2b_count", 32'(o_Fifo_Count), 2);
      gaps = 0;
      for (int c = 2; c < 3 * FRAME; c++) begin
        tick();
        if (!o_Tx_Busy) gaps++;
        if (c == FRAME)     check("b2b_step1", 32'(o_Fifo_Count), 1);
        if (c == 2 * FRAME) check("b2b_step2", 32'(o_Fifo_Count), 0);
      end
      check("b2b_gaps", gaps, 0);
      tick();
      check("b2b_end", o_Tx_Busy, 0);
      drain();
    end

    // Overflow, clear, and set/clear collision
    for (int i = 0; i < 6; i++) begin
      tx_en = 1'b1; pwdata = $urandom; tick();
    end
    tx_en = 1'b0;
    check("ovf_set", o_Ovf, 1);
    check("ovf_count", 32'(o_Fifo_Count), 4);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("ovf_clr", o_Ovf, 0);
    tx_en = 1'b1; ovf_clr = 1'b1; pwdata = $urandom; tick();
    tx_en = 1'b0; ovf_clr = 1'b0;
    check("ovf_set_wins", o_Ovf, 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("ovf_clr2", o_Ovf, 0);
    drain();

    // Reset during data bit 3 with two bytes queued
    begin
      int bad;
      tx_en = 1'b1; pwdata = 32'h3C; tick();
      pwdata = 32'h55; tick();
      pwdata = 32'hC3; tick();
      tx_en = 1'b0;
      repeat (4 * CPB) tick();
      check("midrst_busy_before", o_Tx_Busy, 1);
      rst = 1'b1; tick(); rst = 1'b0;
      check("midrst_count", 32'(o_Fifo_Count), 0);
      bad = 0;
      for (int c = 0; c < 3 * FRAME; c++) begin
        if (o_Tx_Serial !== 1'b1 || o_Tx_Clk !== 1'b1 || o_Tx_Busy !== 1'b0) bad++;
        tick();
      end
      check("midrst_quiet", bad, 0);
    end

    // Randomised traffic against the model
    for (int ph = 0; ph < 3; ph++) begin
      for (int c = 0; c < 1500; c++) begin
        tx_en   = ($urandom_range(0, (ph == 1) ? 3 : 40) == 0);
        pwdata  = $urandom;
        ovf_clr = ($urandom_range(0, 49) == 0);
        rst     = (ph == 2) && ($urandom_range(0, 599) == 0);
        tick();
      end
    end
    tx_en = 1'b0; ovf_clr = 1'b0; rst = 1'b0;
    drain();
    tick();
    check("rx_leftover", exp_tx.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
